// File: rtl/ex_operand_stage.sv
// ex_operand_stage: one-entry pipeline register ahead of the ALU.
// Accepts decoded instructions over valid/ready and holds one at a time.
// Operands are forwarded from EX/MEM and MEM/WB, and B can take the immediate.
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [3:0]        in_alu_ctrl,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_reg_write,
    input  logic [XLEN-1:0]   mwb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic              illegal_op
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_SLT = 4'b1000
    } alu_op_e;

    logic              valid_q;
    logic [XLEN-1:0]   data1_q;
    logic [XLEN-1:0]   data2_q;
    logic [XLEN-1:0]   imm_q;
    logic              use_imm_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic [3:0]        alu_ctrl_q;
    logic              reg_write_q;

    logic              capture;
    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;
    logic              ctrl_defined;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Entry register: flush beats capture, capture beats drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_ctrl_q  <= '0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q     <= 1'b1;
            data1_q     <= in_rs1_data;
            data2_q     <= in_rs2_data;
            imm_q       <= in_imm;
            use_imm_q   <= in_use_imm;
            rs1_q       <= in_rs1;
            rs2_q       <= in_rs2;
            rd_q        <= in_rd;
            alu_ctrl_q  <= in_alu_ctrl;
            reg_write_q <= in_reg_write;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Operand forwarding: EX/MEM over MEM/WB, register 0 never forwarded.
    always_comb begin
        fwd_a = data1_q;
        if (exm_reg_write && (exm_rd == rs1_q) && (rs1_q != '0)) begin
            fwd_a = exm_result;
        end else if (mwb_reg_write && (mwb_rd == rs1_q) && (rs1_q != '0)) begin
            fwd_a = mwb_result;
        end

        fwd_b = data2_q;
        if (exm_reg_write && (exm_rd == rs2_q) && (rs2_q != '0)) begin
            fwd_b = exm_result;
        end else if (mwb_reg_write && (mwb_rd == rs2_q) && (rs2_q != '0)) begin
            fwd_b = mwb_result;
        end
    end

    // Decode whether the held operation code is one the ALU implements.
    always_comb begin
        ctrl_defined = 1'b0;
        case (alu_ctrl_q)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT: ctrl_defined = 1'b1;
            default: ctrl_defined = 1'b0;
        endcase
    end

    assign alu_a         = fwd_a;
    assign alu_b         = use_imm_q ? imm_q : fwd_b;
    assign alu_ctrl      = alu_ctrl_q;
    assign out_rd        = rd_q;
    assign out_valid     = valid_q;
    assign out_reg_write = valid_q && reg_write_q;
    assign illegal_op    = valid_q && !ctrl_defined;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [3:0]  in_alu_ctrl;
    logic        in_reg_write;
    logic [4:0]  exm_rd;
    logic        exm_reg_write;
    logic [31:0] exm_result;
    logic [4:0]  mwb_rd;
    logic        mwb_reg_write;
    logic [31:0] mwb_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        illegal_op;

    int tests_run = 0;
    int tests_failed = 0;

    ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_ctrl(in_alu_ctrl), .in_reg_write(in_reg_write),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .illegal_op(illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic ui, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [3:0] ctrl, input logic rw);
        in_rs1_data  = d1;
        in_rs2_data  = d2;
        in_imm       = imm;
        in_use_imm   = ui;
        in_rs1       = r1;
        in_rs2       = r2;
        in_rd        = rd;
        in_alu_ctrl  = ctrl;
        in_reg_write = rw;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 4'h0, 1'b0);
        exm_rd = 5'd0; exm_reg_write = 1'b0; exm_result = 32'h0;
        mwb_rd = 5'd0; mwb_reg_write = 1'b0; mwb_result = 32'h0;

        // Reset state
        #3;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst out_rd", 32'(out_rd), 32'd0);
        check("rst out_reg_write", 32'(out_reg_write), 32'd0);
        check("rst illegal_op", 32'(illegal_op), 32'd0);
        #9 rst_n = 1'b1;

        // Basic issue
        set_in(32'd5, 32'd3, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'b0001, 1'b1);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        check("issue out_valid", 32'(out_valid), 32'd1);
        check("issue alu_a", alu_a, 32'd5);
        check("issue alu_b", alu_b, 32'd3);
        check("issue alu_ctrl", 32'(alu_ctrl), 32'b0001);
        check("issue in_ready", 32'(in_ready), 32'd1);
        check("issue out_rd", 32'(out_rd), 32'd3);
        check("issue out_reg_write", 32'(out_reg_write), 32'd1);
        check("issue illegal_op", 32'(illegal_op), 32'd0);
        step();
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("drain out_reg_write", 32'(out_reg_write), 32'd0);

        // Forward priority, held under stall
        set_in(32'd1, 32'd2, 32'h0, 1'b0, 5'd7, 5'd7, 5'd4, 4'b0000, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exm_rd = 5'd7; exm_reg_write = 1'b1; exm_result = 32'hAA;
        mwb_rd = 5'd7; mwb_reg_write = 1'b1; mwb_result = 32'hBB;
        #1;
        check("fwd exm alu_a", alu_a, 32'hAA);
        check("fwd exm alu_b", alu_b, 32'hAA);
        exm_reg_write = 1'b0;
        #1;
        check("fwd mwb alu_a", alu_a, 32'hBB);
        check("fwd mwb alu_b", alu_b, 32'hBB);
        mwb_reg_write = 1'b0;
        #1;
        check("fwd none alu_a", alu_a, 32'd1);
        check("fwd none alu_b", alu_b, 32'd2);

        // Register 0 is never forwarded (replaces held entry via drain+capture)
        out_ready = 1'b1;
        exm_rd = 5'd0; exm_reg_write = 1'b1; exm_result = 32'hFFFFFFFF;
        set_in(32'd0, 32'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 4'b0010, 1'b1);
        in_valid = 1'b1;
        step();
        check("r0 out_valid", 32'(out_valid), 32'd1);
        check("r0 alu_a", alu_a, 32'd0);

        // Immediate overrides a matching rs2 forward
        exm_rd = 5'd4; exm_result = 32'h1234;
        set_in(32'd11, 32'd9, 32'hFFFFFFFC, 1'b1, 5'd3, 5'd4, 5'd6, 4'b0000, 1'b1);
        step();
        check("imm alu_b", alu_b, 32'hFFFFFFFC);
        check("imm alu_a", alu_a, 32'd11);
        exm_reg_write = 1'b0;

        // Stall with a waiting instruction, then back-to-back replace
        set_in(32'h100, 32'h200, 32'h0, 1'b0, 5'd6, 5'd0, 5'd8, 4'b0010, 1'b1);
        step();
        out_ready = 1'b0;
        set_in(32'h300, 32'h400, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 4'b0011, 1'b0);
        #1;
        for (int unsigned i = 0; i < 3; i++) begin
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall alu_a", alu_a, 32'h100);
            check("stall alu_b", alu_b, 32'h200);
            check("stall out_rd", 32'(out_rd), 32'd8);
            step();
        end
        exm_rd = 5'd6; exm_reg_write = 1'b1; exm_result = 32'h55;
        #1;
        check("stall fwd alu_a", alu_a, 32'h55);
        exm_reg_write = 1'b0;
        out_ready = 1'b1;
        #1;
        check("unstall in_ready", 32'(in_ready), 32'd1);
        step();
        check("b2b out_valid", 32'(out_valid), 32'd1);
        check("b2b alu_a", alu_a, 32'h300);
        check("b2b alu_ctrl", 32'(alu_ctrl), 32'b0011);
        check("b2b out_rd", 32'(out_rd), 32'd9);
        check("b2b out_reg_write", 32'(out_reg_write), 32'd0);

        // Flush beats a simultaneous capture
        set_in(32'h1, 32'h2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd10, 4'b0000, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush out_reg_write", 32'(out_reg_write), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-stall
        set_in(32'h77, 32'h66, 32'h0, 1'b0, 5'd1, 5'd2, 5'd5, 4'b0001, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst alu_a", alu_a, 32'd0);
        check("arst alu_b", alu_b, 32'd0);
        check("arst alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("arst out_rd", 32'(out_rd), 32'd0);
        check("arst out_reg_write", 32'(out_reg_write), 32'd0);
        check("arst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal and legal operation codes
        out_ready = 1'b1;
        set_in(32'h1, 32'h2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'b0111, 1'b1);
        in_valid = 1'b1;
        step();
        check("ill out_valid", 32'(out_valid), 32'd1);
        check("ill illegal_op", 32'(illegal_op), 32'd1);
        in_alu_ctrl = 4'b1000;
        step();
        check("slt illegal_op", 32'(illegal_op), 32'd0);
        in_alu_ctrl = 4'b0100;
        step();
        check("nor illegal_op", 32'(illegal_op), 32'd0);
        in_alu_ctrl = 4'b1001;
        step();
        check("1001 illegal_op", 32'(illegal_op), 32'd1);
        in_valid = 1'b0;
        step();
        check("idle illegal_op", 32'(illegal_op), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Pipeline register and operand-select stage that sits directly upstream of the ALU. It accepts decoded instructions from the decode stage through a valid/ready handshake and holds one instruction. It drives the ALU operands A and B, resolving register hazards by forwarding from the EX/MEM and MEM/WB results, and selecting the immediate for B when requested. It also supports stall (downstream back-pressure) and flush (branch/exception squash).

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  squash held and incoming instruction
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept
- in_rs1_data, in_rs2_data  in  XLEN  register-file read values
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  B takes immediate instead of rs2
- in_rs1, in_rs2, in_rd  in  REG_AW  register indices
- in_alu_ctrl  in  4  ALU operation code
- in_reg_write  in  1  instruction writes rd
- exm_rd  in  REG_AW  EX/MEM destination
- exm_reg_write  in  1  EX/MEM writes
- exm_result  in  XLEN  EX/MEM ALU result
- mwb_rd  in  REG_AW  MEM/WB destination
- mwb_reg_write  in  1  MEM/WB writes
- mwb_result  in  XLEN  MEM/WB writeback value
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream accepts
- alu_a, alu_b  out  XLEN  ALU operands
- alu_ctrl  out  4  ALU operation code
- out_rd  out  REG_AW  destination index
- out_reg_write  out  1  gated write enable (0 when out_valid=0)
- illegal_op  out  1  held alu_ctrl is not a defined code

## Operation
- Storage is one entry holding data1, data2, imm, use_imm, rs1, rs2, rd, alu_ctrl, reg_write, and valid.
- in_ready = !valid || out_ready. The ready path is combinational from out_ready.
- Capture: on a clock edge with in_valid && in_ready && !flush, load all fields and set valid=1.
- Drain: on a clock edge with valid && out_ready and no capture, clear valid.
- Simultaneous drain and capture: the new instruction replaces the old one; valid stays 1.
- Stall: valid && !out_ready holds all fields unchanged.
- flush: at the next edge, valid=0 and nothing is captured, even if in_valid=1. flush has priority over all other actions. Fields other than valid may keep stale values.
- Forwarding is combinational on the held entry, evaluated every cycle, so it stays correct during stalls. For each source operand (rs1 → fwdA, rs2 → fwdB):
  - If exm_reg_write, exm_rd == rs, and rs != 0: use exm_result.
  - Else if mwb_reg_write, mwb_rd == rs, and rs != 0: use mwb_result.
  - Else: use the held register-file value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- alu_a = fwdA.
- alu_b = use_imm ? imm : fwdB. When use_imm is set, rs2 forwarding is ignored.
- Defined alu_ctrl codes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 nor
  - 1000 slt
- illegal_op = valid && (alu_ctrl not in the defined set). The instruction still issues; trap handling is downstream.
- out_valid = valid. out_reg_write = valid && reg_write.
- Reset (rst_n low, asynchronous): valid=0, all stored fields 0. Consequently out_valid=0, in_ready=1, alu_a=alu_b=0 (rs1/rs2=0 block forwarding), alu_ctrl=0, out_rd=0, out_reg_write=0, illegal_op=0.
- Reset asserted mid-stall discards the held instruction.

## Timing
- Latency is 1 cycle from accepted input to out_valid.
- Throughput is 1 instruction/cycle while out_ready=1.
- alu_a and alu_b are combinational from the registered state plus the exm_*/mwb_* inputs. There is no extra cycle for forwarding.
- in_ready depends combinationally on out_ready; out_valid does not depend combinationally on in_valid.
- Reset deassertion must be synchronised externally; the first capture is allowed on the first edge after release.

## Test plan
- Basic issue: in_rs1_data=5, in_rs2_data=3, alu_ctrl=0001, in_valid=1, out_ready=1 → next cycle out_valid=1, alu_a=5, alu_b=3, alu_ctrl=0001, in_ready=1.
- Forward priority: held rs1=rs2=7; exm_rd=7/exm_reg_write=1/exm_result=0xAA; mwb_rd=7/mwb_reg_write=1/mwb_result=0xBB → alu_a=alu_b=0xAA. Drop exm_reg_write → both 0xBB.
- Register 0 and immediate: rs1=0 with exm_rd=0, exm_reg_write=1, exm_result=0xFFFFFFFF, in_rs1_data=0 → alu_a=0. Separately, use_imm=1, imm=0xFFFFFFFC, rs2 matching exm_rd → alu_b=0xFFFFFFFC.
- Stall and back-to-back:
  - Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs frozen.
  - Change exm_result during the stall → alu_a tracks the new value.
  - Raise out_ready → next instruction captured on the same edge; out_valid stays 1.
- Flush: flush=1 together with in_valid=1 while valid=1 → next cycle out_valid=0, out_reg_write=0, in_ready=1.
- Reset and illegal op:
  - Assert rst_n=0 mid-stall between edges → outputs go to zero immediately.
  - After release, issue alu_ctrl=0111 → out_valid=1, illegal_op=1.
  - Issue alu_ctrl=1000 → illegal_op=0.
